// File: rtl/sseg_capture.sv
// Seven-segment bus monitor: samples the multiplexed active-low anode/segment lines,
// waits for each digit to settle, and decodes it back into per-digit nibble/flags.
module sseg_capture #(
    parameter int N_DIGITS      = 8,
    parameter int STABLE_CYCLES = 4,
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_DIGITS-1:0]   an,
    input  logic [6:0]            seg,
    input  logic                  dp,
    output logic [4*N_DIGITS-1:0] hex,
    output logic [N_DIGITS-1:0]   point,
    output logic [N_DIGITS-1:0]   valid,
    output logic [N_DIGITS-1:0]   blank,
    output logic [N_DIGITS-1:0]   err,
    output logic                  cap_stb,
    output logic [IW-1:0]         cap_idx,
    output logic                  frame_done
);

    localparam int SW = N_DIGITS + 8;

    // {one_zero_found, index}: index of the single low anode bit
    function automatic logic [IW:0] sel_decode(input logic [N_DIGITS-1:0] an_v);
        logic [IW:0] r;
        int          zeros;
        r     = '0;
        zeros = 0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_v[i]) begin
                zeros        = zeros + 1;
                r[IW-1:0]    = IW'(i);
            end else begin
                zeros        = zeros;
            end
        end
        r[IW] = (zeros == 32'sd1);
        return r;
    endfunction

    // {is_hex, is_blank, nibble}
    function automatic logic [5:0] glyph_decode(input logic [6:0] sg);
        logic [5:0] r;
        case (sg)
            7'b0000001: r = {2'b10, 4'h0};
            7'b1001111: r = {2'b10, 4'h1};
            7'b0010010: r = {2'b10, 4'h2};
            7'b0000110: r = {2'b10, 4'h3};
            7'b1001100: r = {2'b10, 4'h4};
            7'b0100100: r = {2'b10, 4'h5};
            7'b0100000: r = {2'b10, 4'h6};
            7'b0001111: r = {2'b10, 4'h7};
            7'b0000000: r = {2'b10, 4'h8};
            7'b0000100: r = {2'b10, 4'h9};
            7'b0001000: r = {2'b10, 4'hA};
            7'b1100000: r = {2'b10, 4'hB};
            7'b0110001: r = {2'b10, 4'hC};
            7'b1000010: r = {2'b10, 4'hD};
            7'b0110000: r = {2'b10, 4'hE};
            7'b0111000: r = {2'b10, 4'hF};
            7'b1111111: r = {2'b01, 4'h0};
            default:    r = {2'b00, 4'h0};
        endcase
        return r;
    endfunction

    logic [SW-1:0]         s_q, s_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [4*N_DIGITS-1:0] hex_q, hex_d;
    logic [N_DIGITS-1:0]   point_q, point_d, valid_q, valid_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d, err_q, err_d;
    logic                  cap_stb_q, cap_stb_d, frame_done_q, frame_done_d;
    logic [IW-1:0]         cap_idx_q, cap_idx_d;

    logic [SW-1:0]         in_s;
    logic [IW:0]           sel_s;
    logic [5:0]            glyph_s;
    logic                  capture_s;
    logic [N_DIGITS-1:0]   seen_nx_s;

    assign in_s      = {an, seg, dp};
    assign sel_s     = sel_decode(s_q[SW-1:8]);
    assign glyph_s   = glyph_decode(s_q[7:1]);
    assign capture_s = (cnt_q == CW'(STABLE_CYCLES)) && !done_q;

    // Run tracking, capture decision and slot/frame update
    always_comb begin
        s_d          = in_s;
        cnt_d        = cnt_q;
        done_d       = done_q;
        seen_d       = seen_q;
        hex_d        = hex_q;
        point_d      = point_q;
        valid_d      = valid_q;
        blank_d      = blank_q;
        err_d        = err_q;
        cap_stb_d    = 1'b0;
        cap_idx_d    = cap_idx_q;
        frame_done_d = 1'b0;
        seen_nx_s    = seen_q;

        // A changing input starts a new run even on the edge that captures the old one
        if (in_s != s_q) begin
            cnt_d  = CW'(1);
            done_d = 1'b0;
        end else begin
            if (cnt_q != CW'(STABLE_CYCLES)) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            done_d = done_q | capture_s;
        end

        if (capture_s && sel_s[IW]) begin
            cap_stb_d          = 1'b1;
            cap_idx_d          = sel_s[IW-1:0];
            point_d[cap_idx_d] = ~s_q[0];
            if (glyph_s[5]) begin
                hex_d[32'(cap_idx_d) * 32'd4 +: 4] = glyph_s[3:0];
                valid_d[cap_idx_d] = 1'b1;
                blank_d[cap_idx_d] = 1'b0;
                err_d[cap_idx_d]   = 1'b0;
            end else if (glyph_s[4]) begin
                valid_d[cap_idx_d] = 1'b1;
                blank_d[cap_idx_d] = 1'b1;
                err_d[cap_idx_d]   = 1'b0;
            end else begin
                valid_d[cap_idx_d] = 1'b0;
                blank_d[cap_idx_d] = 1'b0;
                err_d[cap_idx_d]   = 1'b1;
            end
            seen_nx_s = seen_q | (N_DIGITS'(1) << cap_idx_d);
            if (&seen_nx_s) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d       = seen_nx_s;
            end
        end else begin
            seen_d = seen_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q          <= {SW{1'b1}};
            cnt_q        <= '0;
            done_q       <= 1'b0;
            seen_q       <= '0;
            hex_q        <= '0;
            point_q      <= '0;
            valid_q      <= '0;
            blank_q      <= '0;
            err_q        <= '0;
            cap_stb_q    <= 1'b0;
            cap_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            seen_q       <= seen_d;
            hex_q        <= hex_d;
            point_q      <= point_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            cap_stb_q    <= cap_stb_d;
            cap_idx_q    <= cap_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign hex        = hex_q;
    assign point      = point_q;
    assign valid      = valid_q;
    assign blank      = blank_q;
    assign err        = err_q;
    assign cap_stb    = cap_stb_q;
    assign cap_idx    = cap_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed steps plus random scans, checked against a
// run-length reference model of the capture rules.
module tb_sseg_capture;
    localparam int N = 8;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] hex;
    logic [7:0]  point, valid, blank, err;
    logic        cap_stb, frame_done;
    logic [2:0]  cap_idx;

    sseg_capture #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
        .hex(hex), .point(point), .valid(valid), .blank(blank), .err(err),
        .cap_stb(cap_stb), .cap_idx(cap_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int nvec = 0, nfail = 0;
    int stb_cnt = 0, fd_cnt = 0;

    // Reference model: value and length of the current run of identical samples
    logic [15:0] run_val;
    int          run_len;
    logic [3:0]  m_hex [N];
    bit          m_point [N], m_valid [N], m_blank [N], m_err [N], m_seen [N];
    bit          m_stb, m_fd;
    int          m_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run_len = 0;
        run_val = 16'hFFFF;
        m_stb = 0; m_fd = 0; m_idx = 0;
        for (int i = 0; i < N; i++) begin
            m_hex[i] = 4'h0; m_point[i] = 0; m_valid[i] = 0;
            m_blank[i] = 0; m_err[i] = 0; m_seen[i] = 0;
        end
    endtask

    // A run captures on the edge after its S-th identical sample, once per run
    task automatic model_edge();
        logic [15:0] cur;
        logic [6:0]  g;
        int          zeros, idx, nib;
        bit          all;
        cur = {an, seg, dp};
        m_stb = 0; m_fd = 0;
        if (run_len == S) begin
            zeros = 0; idx = 0;
            for (int i = 0; i < N; i++) if (run_val[8+i] == 1'b0) begin zeros++; idx = i; end
            if (zeros == 1) begin
                m_stb = 1; m_idx = idx;
                g = run_val[7:1];
                nib = -1;
                for (int k = 0; k < 16; k++) if (glyph[k] == g) nib = k;
                m_point[idx] = !run_val[0];
                if (nib >= 0) begin
                    m_hex[idx] = nib[3:0];
                    m_valid[idx] = 1; m_blank[idx] = 0; m_err[idx] = 0;
                end else if (g == 7'h7F) begin
                    m_valid[idx] = 1; m_blank[idx] = 1; m_err[idx] = 0;
                end else begin
                    m_valid[idx] = 0; m_blank[idx] = 0; m_err[idx] = 1;
                end
                m_seen[idx] = 1;
                all = 1;
                for (int i = 0; i < N; i++) if (!m_seen[i]) all = 0;
                if (all) begin
                    m_fd = 1;
                    for (int i = 0; i < N; i++) m_seen[i] = 0;
                end
            end
        end
        if (run_len > 0 && cur == run_val) run_len++;
        else begin run_val = cur; run_len = 1; end
    endtask

    task automatic check_all();
        logic [31:0] eh;
        logic [7:0]  ep, ev, eb, ee;
        for (int i = 0; i < N; i++) begin
            eh[4*i +: 4] = m_hex[i];
            ep[i] = m_point[i]; ev[i] = m_valid[i]; eb[i] = m_blank[i]; ee[i] = m_err[i];
        end
        chk("hex", hex, eh);
        chk("point", {24'd0, point}, {24'd0, ep});
        chk("valid", {24'd0, valid}, {24'd0, ev});
        chk("blank", {24'd0, blank}, {24'd0, eb});
        chk("err", {24'd0, err}, {24'd0, ee});
        chk("cap_stb", {31'd0, cap_stb}, {31'd0, m_stb});
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        if (m_stb) chk("cap_idx", {29'd0, cap_idx}, 32'(m_idx));
    endtask

    task automatic step(input logic [7:0] a, input logic [6:0] sg, input logic d);
        an = a; seg = sg; dp = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (cap_stb === 1'b1) stb_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] sg, input logic d, input int n);
        for (int k = 0; k < n; k++) step(a, sg, d);
    endtask

    initial begin
        logic [7:0] sel;
        int first, dig, pick, dwell;
        logic [6:0] pat;

        rst = 1'b1; an = 8'hFF; seg = 7'h7F; dp = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst = 1'b0;

        // Reset asserted mid-cycle, one edge before a capture would occur
        hold(8'hFE, 7'b0000110, 1'b0, 4);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk) rst = 1'b0;
        stb_cnt = 0;
        hold(8'hFE, 7'b0000110, 1'b0, 3);
        chk("rst_no_stb", 32'(stb_cnt), 32'd0);

        // Single digit
        stb_cnt = 0;
        hold(8'hFB, 7'b0100100, 1'b0, 5);
        chk("single_stb", {31'd0, cap_stb}, 32'd1);
        chk("single_idx", {29'd0, cap_idx}, 32'd2);
        chk("single_hex", {28'd0, hex[11:8]}, 32'd5);
        hold(8'hFB, 7'b0100100, 1'b0, 10);
        chk("single_once", 32'(stb_cnt), 32'd1);

        // Two full scans
        stb_cnt = 0; fd_cnt = 0;
        for (int d = 0; d < N; d++) begin
            sel = 8'd1 << d;
            hold(~sel, glyph[d], 1'b1, 6);
        end
        chk("scan_stb", 32'(stb_cnt), 32'd8);
        chk("scan_hex", hex, 32'h76543210);
        chk("scan_fd1", 32'(fd_cnt), 32'd1);
        for (int d = 0; d < N; d++) begin
            sel = 8'd1 << d;
            hold(~sel, glyph[d], 1'b1, 6);
        end
        chk("scan_fd2", 32'(fd_cnt), 32'd2);

        // Blank then illegal pattern on digit 3
        hold(8'hF7, 7'h7F, 1'b1, 6);
        chk("blank3", {31'd0, blank[3]}, 32'd1);
        chk("blank3_hex", {28'd0, hex[15:12]}, 32'd3);
        hold(8'hF7, 7'b1010101, 1'b1, 6);
        chk("err3", {29'd0, err[3], valid[3], blank[3]}, 32'd4);

        // One-cycle glitch restarts the run
        hold(8'hFD, glyph[9], 1'b1, 2);
        step(8'hFD, glyph[8], 1'b1);
        first = 0;
        for (int k = 1; k <= S + 2; k++) begin
            step(8'hFD, glyph[9], 1'b1);
            if (cap_stb === 1'b1 && first == 0) first = k;
        end
        chk("glitch_lat", 32'(first), 32'(S + 1));

        // Illegal anode patterns
        stb_cnt = 0;
        hold(8'hFC, glyph[1], 1'b0, 10);
        hold(8'hFF, glyph[2], 1'b0, 10);
        chk("bad_an_stb", 32'(stb_cnt), 32'd0);

        // Random scans with varied dwell, glyphs, blanks, junk and bad anodes
        for (int r = 0; r < 80; r++) begin
            dig = $urandom_range(N - 1);
            sel = 8'd1 << dig;
            sel = ~sel;
            pick = $urandom_range(9);
            if (pick == 0) sel = 8'hFF;
            else if (pick == 1) sel = sel & 8'($urandom);
            pick = $urandom_range(9);
            if (pick == 0) pat = 7'h7F;
            else if (pick == 1) pat = 7'($urandom);
            else pat = glyph[$urandom_range(15)];
            dwell = $urandom_range(1, 8);
            hold(sel, pat, 1'($urandom), dwell);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
